// File: rtl/seg_scan_if.sv
// seg_scan_if: bundle between the message/formatting stage and the segment
// scan driver.
//   seg_word_i [31:0] four digit bytes, byte [31:24] = digit 3 (leftmost),
//                     bits[7:1] segments, bit0 dp, all active-low
//   bright_i   [3:0]  brightness, 15 = full, 0 = 1/16
//   en_i              display enable, 0 blanks the pins
//   seg_o      [7:0]  segment/dp pins, active-low
//   an_o       [3:0]  anode selects, active-low, an_o[k] drives digit k
//   frame_o           one-cycle pulse at the start of each scan frame
// master = producer side (drives word/brightness/enable), slave = driver.
interface seg_scan_if;
  logic [31:0] seg_word_i;
  logic [3:0]  bright_i;
  logic        en_i;
  logic [7:0]  seg_o;
  logic [3:0]  an_o;
  logic        frame_o;

  modport master (
    output seg_word_i, bright_i, en_i,
    input  seg_o, an_o, frame_o
  );

  modport slave (
    input  seg_word_i, bright_i, en_i,
    output seg_o, an_o, frame_o
  );
endinterface

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexes a four-digit segment word onto a common
// 4-anode seven-segment display. Each digit owns a slot of DIGIT_CYCLES clocks;
// the first BLANK_CYCLES of every slot keep all anodes off to avoid ghosting.
// A free-running 4-bit PWM counter gates lit cycles against bright_i.
// The input word is latched once per frame (digit 3, slot 0) so a word that
// changes mid-scan never tears the display.
// Ports:
//   clk_i   system clock
//   rstn_i  synchronous active-low reset
//   bus     seg_scan_if.slave (seg_word_i, bright_i, en_i -> seg_o, an_o, frame_o)
// All outputs are registered; the value after edge E reflects the counter
// state at E.
module seg_scan_driver #(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  seg_scan_if.slave  bus
);

  localparam int SW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(DIGIT_CYCLES - 1);
  localparam logic [SW-1:0] BLANK_END = SW'(BLANK_CYCLES);

  logic [SW-1:0] slot_q;
  logic [1:0]    digit_q;
  logic [3:0]    pwm_q;
  logic [31:0]   shadow_q;
  logic [7:0]    seg_q;
  logic [3:0]    an_q;
  logic          frame_q;

  logic          latch;
  logic          lit;
  logic [31:0]   word_src;
  logic [7:0]    cur_byte;
  logic [3:0]    an_sel;

  assign latch = (digit_q == 2'd3) && (slot_q == '0);

  always_comb begin
    // On the latch cycle the shadow is being overwritten; show the incoming
    // word so digit 3 never displays a stale byte when BLANK_CYCLES is 0.
    word_src = latch ? bus.seg_word_i : shadow_q;
    cur_byte = 8'hFF;
    an_sel   = 4'hF;
    case (digit_q)
      2'd3: begin cur_byte = word_src[31:24]; an_sel = 4'b0111; end
      2'd2: begin cur_byte = word_src[23:16]; an_sel = 4'b1011; end
      2'd1: begin cur_byte = word_src[15:8];  an_sel = 4'b1101; end
      2'd0: begin cur_byte = word_src[7:0];   an_sel = 4'b1110; end
      default: begin cur_byte = 8'hFF; an_sel = 4'hF; end
    endcase
  end

  assign lit = bus.en_i && !(slot_q < BLANK_END) && !(pwm_q > bus.bright_i);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      slot_q   <= '0;
      digit_q  <= 2'd3;
      pwm_q    <= 4'd0;
      shadow_q <= 32'hFFFF_FFFF;
      seg_q    <= 8'hFF;
      an_q     <= 4'hF;
      frame_q  <= 1'b0;
    end else begin
      if (slot_q == SLOT_LAST) begin
        slot_q  <= '0;
        digit_q <= digit_q - 2'd1;  // 0 wraps to 3
      end else begin
        slot_q  <= slot_q + 1'b1;
      end
      pwm_q   <= pwm_q + 4'd1;
      frame_q <= latch;
      if (latch) begin
        shadow_q <= bus.seg_word_i;
      end
      an_q  <= lit ? an_sel   : 4'hF;
      seg_q <= lit ? cur_byte : 8'hFF;
    end
  end

  assign bus.seg_o   = seg_q;
  assign bus.an_o    = an_q;
  assign bus.frame_o = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver. dut1 (DIGIT_CYCLES=8, BLANK_CYCLES=2)
// covers reset, scan order, anti-tearing, enable and mid-run reset; dut2
// (DIGIT_CYCLES=64, BLANK_CYCLES=0) covers brightness. Stimulus processes push
// expected per-cycle outputs (keyed by edge number) and per-frame lit counts;
// monitors pop and compare at each negedge.
module tb_seg_scan_driver;

  logic clk_i = 1'b0;
  logic rstn1, rstn2;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  seg_scan_if if1 ();
  seg_scan_if if2 ();

  seg_scan_driver #(.DIGIT_CYCLES(8), .BLANK_CYCLES(2)) dut1 (
    .clk_i(clk_i), .rstn_i(rstn1), .bus(if1.slave));
  seg_scan_driver #(.DIGIT_CYCLES(64), .BLANK_CYCLES(0)) dut2 (
    .clk_i(clk_i), .rstn_i(rstn2), .bus(if2.slave));

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [7:0] seg;
    logic       frame;
    bit         lit_only;
    string      name;
  } exp_t;

  typedef struct {
    int cnt;
    bit iso;
  } cnt_t;

  exp_t q1[$];
  exp_t q2[$];
  cnt_t qc[$];

  logic [3:0] an_tab [4];
  initial begin
    an_tab[0] = 4'b1110; an_tab[1] = 4'b1101;
    an_tab[2] = 4'b1011; an_tab[3] = 4'b0111;
  end

  task automatic push1(input int c, input logic [3:0] an, input logic [7:0] seg,
                       input logic fr, input string nm);
    exp_t e;
    e.cyc = c; e.an = an; e.seg = seg; e.frame = fr; e.lit_only = 1'b0; e.name = nm;
    q1.push_back(e);
  endtask

  // One 32-cycle frame of dut1 starting at frame-pulse edge f; edges beyond
  // 'last' are skipped, edges in [blo,bhi] are expected blank (en_i low).
  task automatic push_frame(input int f, input logic [31:0] w, input int last,
                            input int blo, input int bhi, input string nm);
    int c, d;
    bit lit;
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      for (int s = 0; s < 8; s++) begin
        c = f + 8 * i + s;
        if (c <= last) begin
          d = 3 - i;
          b = w[8 * d +: 8];
          lit = (s >= 2) && !(c >= blo && c <= bhi);
          push1(c, lit ? an_tab[d] : 4'hF, lit ? b : 8'hFF, (i == 0 && s == 0), nm);
        end
      end
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk_i);
  endtask

  // ---------------- monitors ----------------
  task automatic check_inv(input logic [3:0] an, input logic [7:0] seg, input string nm);
    total++;
    if ($countones(~an) > 1 || (an == 4'hF && seg != 8'hFF)) begin
      bad++;
      $display("FAIL %s invariant cyc=%0d got an=%h seg=%h", nm, cyc, an, seg);
    end
  endtask

  always @(negedge clk_i) begin
    if (cyc > 0) begin
      check_inv(if1.an_o, if1.seg_o, "inv1");
      while (q1.size() > 0 && q1[0].cyc <= cyc) begin
        exp_t e;
        e = q1.pop_front();
        total++;
        if (e.cyc < cyc) begin
          bad++;
          $display("FAIL %s missed cyc=%0d now=%0d", e.name, e.cyc, cyc);
        end else if (if1.an_o !== e.an || if1.seg_o !== e.seg || if1.frame_o !== e.frame) begin
          bad++;
          $display("FAIL %s cyc=%0d got an=%b seg=%h frame=%b exp an=%b seg=%h frame=%b",
                   e.name, cyc, if1.an_o, if1.seg_o, if1.frame_o, e.an, e.seg, e.frame);
        end
      end
    end
  end

  int  lit_cnt = 0;
  bit  seen_pulse = 0;
  bit  adj = 0;
  bit  prev_lit = 0;

  always @(negedge clk_i) begin
    bit l;
    if (cyc > 0) begin
      check_inv(if2.an_o, if2.seg_o, "inv2");
      l = (if2.an_o != 4'hF);
      while (q2.size() > 0 && q2[0].cyc <= cyc) begin
        exp_t e;
        e = q2.pop_front();
        total++;
        if (e.cyc < cyc || l != e.frame) begin
          bad++;
          $display("FAIL %s cyc=%0d got lit=%b exp lit=%b", e.name, cyc, l, e.frame);
        end
      end
      if (if2.frame_o === 1'b1) begin
        if (seen_pulse && qc.size() > 0) begin
          cnt_t c;
          c = qc.pop_front();
          total++;
          if (lit_cnt != c.cnt || (c.iso && adj)) begin
            bad++;
            $display("FAIL bright_count cyc=%0d got lit=%0d adjacent=%b exp lit=%0d isolated=%b",
                     cyc, lit_cnt, adj, c.cnt, c.iso);
          end
        end
        seen_pulse = 1;
        lit_cnt = int'(l);
        adj = 0;
      end else begin
        lit_cnt += int'(l);
        if (l && prev_lit) adj = 1;
      end
      prev_lit = l;
    end
  end

  // ---------------- stimulus ----------------
  // Reset held through edges 1..5, released at the negedge after edge 5, so
  // edge 6 is the first with rstn=1 and carries the first frame pulse.
  task automatic stim1();
    for (int c = 1; c <= 5; c++) push1(c, 4'hF, 8'hFF, 1'b0, "reset");
    push_frame(6,   32'h12345678, 1000, 0, -1, "frame0");
    push_frame(38,  32'h12345678, 1000, 0, -1, "frame1");
    push_frame(70,  32'h12345678, 1000, 0, -1, "frame2");
    push_frame(102, 32'h12345678, 1000, 0, -1, "antitear_old");
    push_frame(134, 32'hAABBCCDD, 1000, 0, -1, "antitear_new");
    push_frame(166, 32'hAABBCCDD, 1000, 170, 202, "enable_a");
    push_frame(198, 32'hAABBCCDD, 1000, 170, 202, "enable_b");
    push_frame(230, 32'hAABBCCDD, 249, 0, -1, "pre_reset");
    push1(250, 4'hF, 8'hFF, 1'b0, "mid_reset");
    push_frame(251, 32'h00FF00FF, 1000, 0, -1, "post_reset");

    wait_cyc(5);   rstn1 = 1'b1;
    wait_cyc(112); if1.seg_word_i = 32'hAABBCCDD;   // digit 2 lit
    wait_cyc(169); if1.en_i = 1'b0;                 // digit 3 lit
    wait_cyc(202); if1.en_i = 1'b1;
    wait_cyc(249); rstn1 = 1'b0; if1.seg_word_i = 32'h00FF00FF;  // digit 1 lit
    wait_cyc(250); rstn1 = 1'b1;
    wait_cyc(283);
  endtask

  // dut2 frames pulse at edges 6, 262, 518, 774; pwm value at edge n is (n-6)%16.
  task automatic stim2();
    cnt_t c;
    exp_t e;
    c.cnt = 256; c.iso = 0; qc.push_back(c);
    c.cnt = 128; c.iso = 0; qc.push_back(c);
    c.cnt = 16;  c.iso = 1; qc.push_back(c);
    e.an = 4'hF; e.seg = 8'hFF; e.lit_only = 1'b1; e.name = "bright_step";
    e.cyc = 807; e.frame = 1'b1; q2.push_back(e);
    e.cyc = 808; e.frame = 1'b1; q2.push_back(e);
    e.cyc = 809; e.frame = 1'b0; q2.push_back(e);
    e.cyc = 810; e.frame = 1'b0; q2.push_back(e);

    wait_cyc(5);   rstn2 = 1'b1;
    wait_cyc(261); if2.bright_i = 4'd7;
    wait_cyc(517); if2.bright_i = 4'd0;
    wait_cyc(773); if2.bright_i = 4'd15;
    wait_cyc(808); if2.bright_i = 4'd0;   // mid-slot drop, pwm was 2
    wait_cyc(812);
  endtask

  initial begin
    rstn1 = 1'b0; rstn2 = 1'b0;
    if1.seg_word_i = 32'h12345678; if1.bright_i = 4'd15; if1.en_i = 1'b1;
    if2.seg_word_i = 32'h12345678; if2.bright_i = 4'd15; if2.en_i = 1'b1;
    fork
      stim1();
      stim2();
    join
    for (int i = 0; i < 50; i++) begin
      if (q1.size() == 0 && q2.size() == 0 && qc.size() == 0) break;
      @(negedge clk_i);
    end
    if (q1.size() != 0 || q2.size() != 0 || qc.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain got pending=%0d exp pending=0", q1.size() + q2.size() + qc.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got time=%0t exp finish before limit", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Consumes the 32-bit four-digit segment word produced by the message/formatting stage.
- Time-multiplexes that word onto a common 4-anode seven-segment display, with inter-digit blanking to prevent ghosting and 16-level PWM brightness control.
- Latches the input word once per frame so a word that changes mid-scan never tears the display.
- Sits between the message stage and the board pins.

Parameters:
- DIGIT_CYCLES, 50000: clock cycles per digit slot; must be >= 2.
- BLANK_CYCLES, 500: cycles at the start of each slot with all anodes off; must be < DIGIT_CYCLES.

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  reset; synchronous, active-low
- seg_word_i  in  32  four digit bytes. Byte [31:24] is the leftmost digit (digit 3); byte [7:0] is digit 0. Per byte, bits[7:1] are segments and bit0 is dp. All active-low (1 = off).
- bright_i  in  4  brightness level; 15 = full, 0 = 1/16
- en_i  in  1  display enable; 0 blanks outputs
- seg_o  out  8  segment/dp lines in the same byte format, active-low
- an_o  out  4  anode selects, active-low; an_o[k] drives digit k
- frame_o  out  1  one-cycle pulse marking the start of a frame

Behaviour:
- Reset (rstn_i=0 at a clk_i edge) sets:
  - an_o=4'hF, seg_o=8'hFF, frame_o=0
  - slot counter=0, digit index=3, pwm counter=0
  - shadow word=32'hFFFFFFFF
- Counters:
  - Slot counter runs 0..DIGIT_CYCLES-1, width $clog2(DIGIT_CYCLES).
  - On wrap, the digit index decrements 3→2→1→0→3.
  - Frame length is 4*DIGIT_CYCLES.
  - The 4-bit pwm counter is free-running and increments every cycle, wrapping 15→0.
  - All counters run regardless of en_i and bright_i.
- Frame latch: on any edge where the counter state is (digit=3, slot=0) and rstn_i=1:
  - shadow <= seg_word_i;
  - frame_o=1 for that single following cycle.
  - seg_word_i is not sampled at any other time.
- Outputs are registered. The output value after edge E reflects the counter state at E.
- Output decode, evaluated on counter state at each edge:
  - blank (an_o=F, seg_o=FF) if en_i=0;
  - else blank if slot < BLANK_CYCLES;
  - else blank if pwm > bright_i;
  - else an_o = one-hot-low at the current digit, and seg_o = shadow byte of the current digit.
- Invariants:
  - At most one an_o bit is low in any cycle.
  - seg_o=FF whenever an_o=F.
  - Between two different digits being lit there are at least BLANK_CYCLES blank cycles.
- en_i deassert: blank on the next output cycle. Counters and frame_o are unaffected. On reassert, display resumes in phase with no restart.
- bright_i is sampled every cycle (no latching). A change takes effect on the next decoded cycle.
- Reset mid-frame: the next output cycle shows reset values. The first frame after release latches on the first edge with rstn_i=1.
- Pin-level sync/debounce is out of scope; all inputs are synchronous to clk_i.

Test Plan:
All tests use DIGIT_CYCLES=8 and BLANK_CYCLES=2 unless noted; en_i=1, bright_i=15.
1. Reset and first frame:
   - Stimulus: rstn_i=0 for 5 cycles with seg_word_i=32'h12345678, then release at edge E0.
   - During reset: an_o=F, seg_o=FF, frame_o=0.
   - After E1: frame_o=1 for one cycle, outputs blank.
   - After E3: an_o=4'b0111, seg_o=8'h12, held 6 cycles.
   - After E9: blank for 2 cycles, then an_o=4'b1011, seg_o=8'h34.
   - frame_o repeats every 32 cycles.
2. Scan order and wrap:
   - Observe 3 frames.
   - Lit order is digit 3,2,1,0,3 with 8-cycle period and 6 lit cycles per slot.
   - Never two anodes low; seg_o=FF in every blank cycle.
3. Anti-tearing:
   - Change seg_word_i to 32'hAABBCCDD while digit 2 is lit.
   - Digits 2,1,0 still show 34,56,78 this frame.
   - AA/BB/CC/DD appear only after the next frame_o pulse.
4. Brightness (DIGIT_CYCLES=64, BLANK_CYCLES=0):
   - bright_i=15: 256 lit cycles per frame.
   - bright_i=7: 128 lit cycles per frame.
   - bright_i=0: 16 lit cycles per frame, each isolated (pwm=0 only).
   - Change 15→0 mid-slot: the effect is visible on the next output cycle.
5. Enable:
   - Drop en_i mid-lit-digit: blank on the next output cycle, while frame_o keeps its 32-cycle cadence.
   - Raise en_i: lighting resumes at the digit/slot dictated by the undisturbed counters.
6. Reset mid-operation:
   - Assert rstn_i=0 for 1 cycle during digit 1 lit: next cycle an_o=F, seg_o=FF.
   - Shadow is cleared: with seg_word_i changed to 32'h00FF00FF before release, the new word appears from the first post-reset frame.
